usb_rx_line_frontend: RTL and testbench

USB_RX_LINE_FRONTEND -- requirements
Module: usb_rx_line_frontend

---
 rtl/usb_rx_pkg.sv | 17 +
 rtl/usb_rx_sync.sv | 16 +
 rtl/usb_rx_line_frontend.sv | 125 ++++++++++++
 tb/tb_usb_rx_line_frontend.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared line-state and receiver-state types for the USB receive front end.
package usb_rx_pkg;
  // Encoding is {D+, D-} so the synchronized pair casts straight to a line state.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_SE0_SEEN,
    ST_ERR_WAIT
  } fe_state_t;
  localparam int STUFF_LIMIT_DEFAULT = 6;
endpackage

// File: rtl/usb_rx_sync.sv
// usb_rx_sync: two-flop synchronizer for one raw bus line.
// Ports: clk, rst (sync, active-high), d_i raw async input, q_o synchronized output.
module usb_rx_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk) begin
    if (rst) {q_o, meta_q} <= {RST_VAL, RST_VAL};
    else     {q_o, meta_q} <= {meta_q, d_i};
  end
endmodule

// File: rtl/usb_rx_line_frontend.sv
// usb_rx_line_frontend: USB receive line front end -- synchronizes D+/D-, recovers bit timing,
// NRZI-decodes and unstuffs bits, and detects end-of-packet and line errors.
// Ports: clk, rst (sync, active-high); dplus_in/dminus_in raw lines; enable receive permit;
//        bit_valid/bit_data decoded bit strobe; eop, line_error one-cycle pulses;
//        rx_active packet in progress; line_idle idle with line at J. All outputs registered.
module usb_rx_line_frontend
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = STUFF_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic dplus_in,
  input  logic dminus_in,
  input  logic enable,
  output logic bit_valid,
  output logic bit_data,
  output logic eop,
  output logic line_error,
  output logic rx_active,
  output logic line_idle
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  logic dp_s, dm_s, change, strobe, dec, at_limit;
  line_state_t ls, ls_q, prev_q;
  fe_state_t state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] ones_q;
  logic se0_q;
  usb_rx_sync #(.RST_VAL(1'b1)) u_sync_dp (.clk(clk), .rst(rst), .d_i(dplus_in), .q_o(dp_s));
  usb_rx_sync #(.RST_VAL(1'b0)) u_sync_dm (.clk(clk), .rst(rst), .d_i(dminus_in), .q_o(dm_s));
  // Bit timing re-aligns on every line transition; the strobe lands mid-bit.
  always_comb begin
    ls       = line_state_t'({dp_s, dm_s});
    change   = ls != ls_q;
    cnt_d    = change || cnt_q == CW'(CLKS_PER_BIT - 1) ? '0 : cnt_q + 1'b1;
    strobe   = !change && cnt_q == CW'(CLKS_PER_BIT / 2);
    dec      = ls == prev_q;
    at_limit = ones_q == OW'(STUFF_LIMIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ls_q  <= LS_J;
      cnt_q <= '0;
    end else begin
      ls_q  <= ls;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= LS_J;
      ones_q     <= '0;
      se0_q      <= 1'b0;
      bit_valid  <= 1'b0;
      bit_data   <= 1'b0;
      eop        <= 1'b0;
      line_error <= 1'b0;
      rx_active  <= 1'b0;
      line_idle  <= 1'b1;
    end else begin
      bit_valid  <= 1'b0;
      eop        <= 1'b0;
      line_error <= 1'b0;
      line_idle  <= state_q == ST_IDLE && ls == LS_J;
      if (!enable) begin
        state_q   <= ST_IDLE;
        rx_active <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ls == LS_K) begin
              state_q   <= ST_RECEIVE;
              prev_q    <= LS_J;
              ones_q    <= '0;
              rx_active <= 1'b1;
            end
          end
          ST_RECEIVE: begin
            if (strobe) begin
              if (ls == LS_SE0) begin
                state_q <= ST_SE0_SEEN;
              end else if (ls == LS_SE1 || (at_limit && dec)) begin
                // SE1 mid-packet, or a 1 where a stuffed 0 was mandatory.
                line_error <= 1'b1;
                rx_active  <= 1'b0;
                se0_q      <= 1'b0;
                state_q    <= ST_ERR_WAIT;
              end else begin
                prev_q <= ls;
                if (at_limit) begin
                  ones_q <= '0;
                end else begin
                  bit_valid <= 1'b1;
                  bit_data  <= dec;
                  ones_q    <= dec ? ones_q + 1'b1 : '0;
                end
              end
            end
          end
          ST_SE0_SEEN: begin
            if (strobe && ls == LS_J) begin
              eop       <= 1'b1;
              rx_active <= 1'b0;
              state_q   <= ST_IDLE;
            end else if (strobe && ls != LS_SE0) begin
              line_error <= 1'b1;
              rx_active  <= 1'b0;
              se0_q      <= 1'b0;
              state_q    <= ST_ERR_WAIT;
            end
          end
          ST_ERR_WAIT: begin
            // Wait out the broken packet: leave only after an SE0 bit and then a J bit.
            if (strobe && ls == LS_SE0) se0_q <= 1'b1;
            else if (strobe && ls == LS_J && se0_q) state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_rx_line_frontend.sv
// tb_usb_rx_line_frontend: table-driven and random packet checks for usb_rx_line_frontend.
module tb_usb_rx_line_frontend;
  localparam logic [1:0] J = 2'b10, K = 2'b01, S0 = 2'b00, S1 = 2'b11;
  logic clk = 1'b0, rst = 1'b1, dplus_in = 1'b1, dminus_in = 1'b0, enable = 1'b1;
  logic bit_valid, bit_data, eop, line_error, rx_active, line_idle;
  usb_rx_line_frontend #(.CLKS_PER_BIT(8), .STUFF_LIMIT(6)) dut (
    .clk(clk), .rst(rst), .dplus_in(dplus_in), .dminus_in(dminus_in), .enable(enable),
    .bit_valid(bit_valid), .bit_data(bit_data), .eop(eop), .line_error(line_error),
    .rx_active(rx_active), .line_idle(line_idle)
  );
  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n++;
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  bit q_bits[$];
  int q_bcyc[$];
  int st[$];
  int n_eop = 0, n_err = 0, eop_cyc = 0;
  logic prev_rx = 1'b0, idle_chk = 1'b0;
  always @(negedge clk) begin
    if (idle_chk) begin
      chk("line_idle_after_eop", line_idle, 1);
      idle_chk = 1'b0;
    end
    if (bit_valid) begin
      q_bits.push_back(bit_data);
      q_bcyc.push_back(cyc_n);
    end
    if (eop) begin
      n_eop++;
      eop_cyc = cyc_n;
      chk("eop_exclusive", {line_error, bit_valid}, 0);
      chk("rx_active_at_eop", rx_active, 0);
      chk("rx_active_before_eop", prev_rx, 1);
      idle_chk = 1'b1;
    end
    if (line_error) begin
      n_err++;
      chk("rx_active_at_err", rx_active, 0);
    end
    prev_rx = rx_active;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear();
    q_bits.delete();
    q_bcyc.delete();
    st.delete();
    n_eop = 0;
    n_err = 0;
  endtask
  // Transmit-side model: bit list -> stuffed, NRZI-encoded symbol list.
  bit tx_bits[$];
  logic [1:0] syms[$];
  task automatic add_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) tx_bits.push_back(d[i]);
  endtask
  task automatic build(input bit stuff);
    logic [1:0] lvl;
    int ones;
    lvl = J;
    ones = 0;
    syms.delete();
    foreach (tx_bits[i]) begin
      if (!tx_bits[i]) lvl = ~lvl;
      ones = tx_bits[i] ? ones + 1 : 0;
      syms.push_back(lvl);
      if (stuff && ones == 6) begin
        lvl = ~lvl;
        syms.push_back(lvl);
        ones = 0;
      end
    end
  endtask
  task automatic add_eop();
    syms.push_back(S0);
    syms.push_back(S0);
    repeat (3) syms.push_back(J);
  endtask
  task automatic send(input bit jit, input int n);
    for (int i = 0; i < n; i++) begin
      {dplus_in, dminus_in} = syms[i];
      st.push_back(cyc_n);
      cyc(jit ? (i % 2 ? 9 : 7) : 8);
    end
  endtask
  task automatic run_pkt(input logic [7:0] d, input bit jit, input logic [15:0] exp, input string nm);
    logic [15:0] got;
    clear();
    tx_bits.delete();
    add_byte(8'h80);
    add_byte(d);
    build(1'b1);
    add_eop();
    send(jit, syms.size());
    cyc(4);
    got = '0;
    foreach (q_bits[i]) if (i < 16) got[i] = q_bits[i];
    chk({nm, "_count"}, q_bits.size(), 16);
    chk({nm, "_bits"}, got, exp);
    chk({nm, "_eop"}, n_eop, 1);
    chk({nm, "_err"}, n_err, 0);
  endtask
  typedef struct packed {
    logic [7:0]  d;
    logic        jit;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[6];
  initial begin
    int bad, jidx, mism, nb;
    logic [7:0] d;
    tbl[0] = '{8'hA5, 1'b0, 16'hA580};
    tbl[1] = '{8'hFF, 1'b0, 16'hFF80};
    tbl[2] = '{8'h7E, 1'b0, 16'h7E80};
    tbl[3] = '{8'h7E, 1'b1, 16'h7E80};
    tbl[4] = '{8'h00, 1'b1, 16'h0080};
    tbl[5] = '{8'hFF, 1'b1, 16'hFF80};
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_bit_data", bit_data, 0);
    chk("rst_eop", eop, 0);
    chk("rst_line_error", line_error, 0);
    chk("rst_rx_active", rx_active, 0);
    chk("rst_line_idle", line_idle, 1);
    clear();
    cyc(50);
    chk("idle_pulses", q_bits.size() + n_eop + n_err, 0);
    chk("idle_line_idle", line_idle, 1);
    chk("idle_rx_active", rx_active, 0);
    // Timing of the basic packet: first bit, spacing, and eop latency.
    clear();
    tx_bits.delete();
    add_byte(8'h80);
    add_byte(8'hA5);
    build(1'b1);
    add_eop();
    jidx = syms.size() - 3;
    send(1'b0, syms.size());
    cyc(4);
    chk("a5_first_latency", q_bcyc.size() > 0 ? q_bcyc[0] - st[0] : -1, 8);
    bad = 0;
    for (int i = 1; i < q_bcyc.size(); i++) if (q_bcyc[i] - q_bcyc[i-1] != 8) bad++;
    chk("a5_spacing", bad, 0);
    chk("a5_eop_latency", eop_cyc - st[jidx], 8);
    foreach (tbl[i]) run_pkt(tbl[i].d, tbl[i].jit, tbl[i].exp, $sformatf("tbl%0d", i));
    // Seven unstuffed ones after a zero.
    clear();
    tx_bits.delete();
    add_byte(8'h80);
    tx_bits.push_back(1'b0);
    repeat (7) tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1);
    build(1'b0);
    add_eop();
    send(1'b0, syms.size());
    cyc(4);
    chk("stufferr_bits", q_bits.size(), 15);
    chk("stufferr_err", n_err, 1);
    chk("stufferr_eop", n_eop, 0);
    chk("stufferr_idle", line_idle, 1);
    // SE1 in the middle of a packet.
    clear();
    tx_bits.delete();
    add_byte(8'h80);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    build(1'b1);
    syms.push_back(S1);
    add_eop();
    send(1'b0, syms.size());
    cyc(4);
    chk("se1_bits", q_bits.size(), 10);
    chk("se1_err", n_err, 1);
    chk("se1_eop", n_eop, 0);
    run_pkt(8'h5A, 1'b0, 16'h5A80, "after_err");
    // Abandon mid-byte: mode 0 drops enable, mode 1 asserts rst.
    for (int m = 0; m < 2; m++) begin
      clear();
      tx_bits.delete();
      add_byte(8'h80);
      add_byte(8'hA5);
      build(1'b1);
      send(1'b0, 12);
      {dplus_in, dminus_in} = syms[12];
      cyc(3);
      if (m == 0) enable = 1'b0;
      else rst = 1'b1;
      if (m == 1) {dplus_in, dminus_in} = J;
      cyc(1);
      chk($sformatf("abort%0d_rx_active", m), rx_active, 0);
      if (m == 0) begin
        for (int i = 0; i < 10; i++) begin
          {dplus_in, dminus_in} = $urandom_range(0, 1) ? J : K;
          cyc(4);
        end
      end else cyc(1);
      rst = 1'b0;
      {dplus_in, dminus_in} = J;
      cyc(16);
      enable = 1'b1;
      cyc(16);
      chk($sformatf("abort%0d_bits", m), q_bits.size(), 12);
      chk($sformatf("abort%0d_eop", m), n_eop, 0);
      chk($sformatf("abort%0d_err", m), n_err, 0);
      chk($sformatf("abort%0d_idle", m), line_idle, 1);
      run_pkt(8'hC3, 1'b0, 16'hC380, $sformatf("abort%0d_next", m));
    end
    // Random multi-byte packets: the receiver must return exactly the transmitted bits.
    for (int p = 0; p < 20; p++) begin
      clear();
      tx_bits.delete();
      add_byte(8'h80);
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        d = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
        add_byte(d);
      end
      build(1'b1);
      add_eop();
      send(1'b0, syms.size());
      cyc(4);
      mism = 0;
      foreach (q_bits[i]) if (i >= tx_bits.size() || q_bits[i] != tx_bits[i]) mism++;
      chk($sformatf("rnd%0d_count", p), q_bits.size(), tx_bits.size());
      chk($sformatf("rnd%0d_bits", p), mism, 0);
      chk($sformatf("rnd%0d_eop", p), n_eop, 1);
      chk($sformatf("rnd%0d_err", p), n_err, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
